// File: rtl/src_reg_rd_seq.sv
// Read-side sequencer: walks source registers 0..COUNT-1 in order, pulses a
// one-hot read select for each one, and hands each captured word downstream
// under a valid/ready handshake. Every output is decoded from registered state.
module src_reg_rd_seq #(
  parameter int WIDTH = 4
) (
  input  logic             CLK1,
  input  logic             RST_N,
  input  logic             LDS,
  input  logic [1:0]       COUNT,
  input  logic             ABORT,
  input  logic [WIDTH-1:0] REG0,
  input  logic [WIDTH-1:0] REG1,
  input  logic [WIDTH-1:0] REG2,
  input  logic             DREADY,
  output logic             R0,
  output logic             R1,
  output logic             R2,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] sel_word;

  // Source register addressed by the pointer; only meaningful during LOAD.
  always_comb begin
    case (ptr_q)
      2'd0:    sel_word = REG0;
      2'd1:    sel_word = REG1;
      default: sel_word = REG2;
    endcase
  end

  // Next-state logic: ABORT overrides everything once a sequence is running.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;

    if (ABORT && (state_q != S_IDLE)) begin
      // DOUT deliberately keeps its last captured value on abort.
      state_d = S_IDLE;
      ptr_d   = 2'd0;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // COUNT=0 is a null request and is dropped silently.
          if (LDS && (COUNT != 2'd0)) begin
            cnt_d   = COUNT;
            ptr_d   = 2'd0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          dout_d  = sel_word;
          state_d = S_SEND;
        end
        S_SEND: begin
          if (DREADY) begin
            if (ptr_q == (cnt_q - 2'd1)) begin
              state_d = S_FIN;
            end else begin
              ptr_d   = ptr_q + 2'd1;
              state_d = S_LOAD;
            end
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
          ptr_d   = 2'd0;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // State, pointer, latched count and output word registers.
  always_ff @(posedge CLK1 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 2'd0;
      dout_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign R0     = (state_q == S_LOAD) && (ptr_q == 2'd0);
  assign R1     = (state_q == S_LOAD) && (ptr_q == 2'd1);
  assign R2     = (state_q == S_LOAD) && (ptr_q == 2'd2);
  assign DVALID = (state_q == S_SEND);
  assign BUSY   = (state_q != S_IDLE);
  assign DONE   = (state_q == S_FIN);
  assign DOUT   = dout_q;

endmodule

// File: tb/tb_src_reg_rd_seq.sv
// Bench for src_reg_rd_seq: directed timing scenarios plus randomized
// sequences; a negedge monitor compares selects, words and DONE against
// expectations queued when each request is issued.
module tb_src_reg_rd_seq;
  localparam int W = 4;

  logic         CLK1 = 1'b0;
  logic         RST_N, LDS, ABORT, DREADY;
  logic [1:0]   COUNT;
  logic [W-1:0] REG0, REG1, REG2, DOUT;
  logic         R0, R1, R2, DVALID, BUSY, DONE;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_word_q[$];
  int           exp_sel_q[$];
  int           exp_done_q[$];
  int           rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready

  src_reg_rd_seq #(.WIDTH(W)) dut (
    .CLK1(CLK1), .RST_N(RST_N), .LDS(LDS), .COUNT(COUNT), .ABORT(ABORT),
    .REG0(REG0), .REG1(REG1), .REG2(REG2), .DREADY(DREADY),
    .R0(R0), .R1(R1), .R2(R2), .DOUT(DOUT), .DVALID(DVALID),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK1 = ~CLK1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [5:0] flags();
    return {R2, R1, R0, DVALID, DONE, BUSY};
  endfunction

  // DREADY changes 2 time units after each rising edge.
  initial begin : dready_drv
    DREADY = 1'b0;
    forever begin
      @(posedge CLK1);
      #2;
      case (rdy_mode)
        0:       DREADY = 1'($urandom_range(0, 1));
        1:       DREADY = 1'b1;
        default: DREADY = 1'b0;
      endcase
    end
  end

  // Monitor: samples on the falling edge and consumes expectations.
  initial begin : monitor
    logic [2:0]   sel;
    logic         pend;
    logic [W-1:0] held;
    int           e;
    pend = 1'b0;
    held = '0;
    forever begin
      @(negedge CLK1);
      if (!RST_N) begin
        pend = 1'b0;
      end else begin
        sel = {R2, R1, R0};
        if (sel != 3'b000) begin
          if (exp_sel_q.size() == 0) flag("unexpected_sel");
          else begin
            e = exp_sel_q.pop_front();
            check("rd_sel", 32'(sel), 32'(1) << e);
          end
        end
        if (DVALID && pend) check("dout_hold", 32'(DOUT), 32'(held));
        if (DVALID && DREADY && !ABORT) begin
          if (exp_word_q.size() == 0) flag("unexpected_word");
          else check("dout", 32'(DOUT), 32'(exp_word_q.pop_front()));
          pend = 1'b0;
        end else begin
          pend = DVALID;
          held = DOUT;
        end
        if (DONE) begin
          if (exp_done_q.size() == 0) flag("unexpected_done");
          else begin
            void'(exp_done_q.pop_front());
            check("done_drain", exp_word_q.size() + exp_sel_q.size(), 0);
          end
        end
      end
    end
  end

  // Reference: a request reads registers 0..cnt-1 in order, yields their
  // values as words and ends in one DONE; cnt=0 yields nothing.
  task automatic start(input logic [1:0] cnt);
    logic [W-1:0] regs[3];
    regs[0] = REG0; regs[1] = REG1; regs[2] = REG2;
    COUNT = cnt;
    LDS   = 1'b1;
    for (int i = 0; i < int'(cnt); i++) begin
      exp_sel_q.push_back(i);
      exp_word_q.push_back(regs[i]);
    end
    if (cnt != 2'd0) exp_done_q.push_back(1);
    @(posedge CLK1); #1;
    LDS   = 1'b0;
    COUNT = 2'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < 200) begin
      @(posedge CLK1); #1;
      n++;
    end
    if (BUSY) flag("idle_timeout");
  endtask

  task automatic clear_sb();
    exp_word_q.delete();
    exp_sel_q.delete();
    exp_done_q.delete();
  endtask

  task automatic check_drained(input string name);
    check(name, exp_word_q.size() + exp_sel_q.size() + exp_done_q.size(), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    logic [5:0]   fr_flags[8];
    logic [W-1:0] fr_dout[8];
    int           first_done, first_r1;

    RST_N = 1'b0; LDS = 1'b0; ABORT = 1'b0; COUNT = 2'd0;
    REG0 = '0; REG1 = '0; REG2 = '0;

    // Reset state
    repeat (2) @(posedge CLK1);
    #1;
    check("reset_flags", 32'(flags()), 0);
    check("reset_dout", 32'(DOUT), 0);
    RST_N = 1'b1;
    @(posedge CLK1); #1;
    check("post_reset_idle", 32'(flags()), 0);

    // Full read, DREADY tied high, cycle-exact
    fr_flags = '{6'b001001, 6'b000101, 6'b010001, 6'b000101,
                 6'b100001, 6'b000101, 6'b000011, 6'b000000};
    fr_dout  = '{4'h0, 4'h3, 4'h3, 4'h5, 4'h5, 4'hC, 4'hC, 4'hC};
    rdy_mode = 1;
    REG0 = 4'h3; REG1 = 4'h5; REG2 = 4'hC;
    start(2'd3);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) begin @(posedge CLK1); #1; end
      check($sformatf("full_flags_E%0d", k), 32'(flags()), 32'(fr_flags[k]));
      check($sformatf("full_dout_E%0d", k), 32'(DOUT), 32'(fr_dout[k]));
    end
    check_drained("full_drained");

    // Backpressure: COUNT=2, DREADY low for 3 cycles after first DVALID
    REG0 = 4'h9; REG1 = 4'h6; REG2 = 4'h1;
    rdy_mode = 2;
    start(2'd2);                       // now E0+1
    first_done = -1; first_r1 = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK1); #1;
      if (k == 4) begin
        check("bp_dout_held", 32'(DOUT), 32'h9);
        rdy_mode = 1;                  // DREADY high from the E5 sample on
      end
      if (R1 && first_r1 < 0) first_r1 = k;
      if (DONE && first_done < 0) first_done = k;
    end
    check("bp_r1_edge", first_r1, 5);
    check("bp_done_edge", first_done, 7);
    check_drained("bp_drained");

    // COUNT=1: single word, DONE at E2
    REG0 = 4'h7;
    start(2'd1);
    first_done = -1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge CLK1); #1;
      if (DONE && first_done < 0) first_done = k;
    end
    check("cnt1_done_edge", first_done, 2);
    check_drained("cnt1_drained");

    // COUNT=0: request ignored
    start(2'd0);
    for (int k = 1; k <= 3; k++) begin
      check("cnt0_idle", 32'(flags()), 0);
      @(posedge CLK1); #1;
    end

    // Abort during the second SEND
    REG0 = 4'h2; REG1 = 4'hD; REG2 = 4'h4;
    start(2'd3);                       // E0+1
    repeat (3) begin @(posedge CLK1); #1; end   // E3+1: second SEND
    check("abort_in_send2", {DVALID, DOUT}, {1'b1, 4'hD});
    ABORT = 1'b1;
    @(posedge CLK1); #1;
    ABORT = 1'b0;
    check("abort_flags", 32'(flags()), 0);
    check("abort_dout_kept", 32'(DOUT), 32'hD);
    check("abort_pending_words", exp_word_q.size(), 2);
    clear_sb();
    repeat (4) begin @(posedge CLK1); #1; end
    check("abort_still_idle", 32'(flags()), 0);

    // LDS while busy is ignored
    REG0 = 4'hA; REG1 = 4'hB; REG2 = 4'hE;
    rdy_mode = 0;
    start(2'd3);
    @(posedge CLK1); #1;
    LDS = 1'b1; COUNT = 2'd1;
    @(posedge CLK1); #1;
    LDS = 1'b0;
    wait_idle();
    check_drained("ign_drained");
    repeat (4) begin @(posedge CLK1); #1; end
    check("ign_no_restart", 32'(BUSY), 0);

    // Asynchronous reset mid-SEND with DOUT=0xA
    REG0 = 4'hA;
    rdy_mode = 2;
    start(2'd1);
    @(posedge CLK1); #3;
    check("rst_pre_send", {DVALID, DOUT}, {1'b1, 4'hA});
    RST_N = 1'b0;
    #1;
    check("rst_async_flags", 32'(flags()), 0);
    check("rst_async_dout", 32'(DOUT), 0);
    clear_sb();
    @(posedge CLK1); #1;
    RST_N = 1'b1;
    rdy_mode = 1;
    repeat (4) begin @(posedge CLK1); #1; end
    check("rst_release_idle", 32'(flags()), 0);

    // Randomized sequences with random backpressure
    rdy_mode = 0;
    for (int t = 0; t < 60; t++) begin
      REG0 = W'($urandom); REG1 = W'($urandom); REG2 = W'($urandom);
      start(2'($urandom_range(0, 3)));
      wait_idle();
      if ($urandom_range(0, 1) == 1) begin @(posedge CLK1); #1; end
    end
    repeat (2) begin @(posedge CLK1); #1; end
    check_drained("rand_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
